// File: rtl/char_motion_ctrl_pkg.sv
// Shared game constants, state encodings and the LFSR step for the character motion stage.
// Screen, sprite sizes and Event bit positions live here so every file agrees on them.
package char_motion_ctrl_pkg;

   localparam int SCREEN_W    = 640;
   localparam int SCREEN_H    = 480;
   localparam int DRAGON_W    = 40;
   localparam int DRAGON_H    = 30;
   localparam int ROBOT_W     = 40;
   localparam int ROBOT_H     = 30;
   localparam int MISSILE_W   = 56;
   localparam int MISSILE_H   = 12;

   localparam logic [9:0] D_Y0        = 10'd60;
   localparam logic [9:0] D1_Y0       = 10'd200;
   localparam logic [9:0] D2_Y0       = 10'd340;
   localparam logic [9:0] ROBOT_X     = 10'd20;
   localparam logic [9:0] ROBOT_Y0    = 10'd225;
   localparam logic [9:0] ROBOT_Y_MAX = 10'd450;

   // The missile spawns at the robot's nose, vertically centred on the robot.
   localparam logic [9:0] MISSILE_X_OFF = 10'd40;
   localparam logic [9:0] MISSILE_Y_OFF = 10'd9;
   localparam logic [9:0] MISSILE_X_MAX = 10'(SCREEN_W - MISSILE_W - 1);

   localparam logic [9:0] SPAWN_Y_BASE = 10'd40;
   localparam logic [7:0] LFSR_SEED    = 8'hA5;

   // Event = {d, d1, d2, r}
   localparam int EV_D  = 3;
   localparam int EV_D1 = 2;
   localparam int EV_D2 = 1;
   localparam int EV_R  = 0;

   typedef enum logic {SLOT_ALIVE, SLOT_DEAD} slot_state_e;
   typedef enum logic {M_IDLE, M_FLY} missile_state_e;

   // Fibonacci form of x^8 + x^6 + x^5 + x^4 + 1.
   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

endpackage

// File: rtl/char_motion_ctrl_if.sv
// Bundle between the motion controller and its neighbours: controls and Event in, sprite state out.
// master drives the controls and reads positions; slave is the motion controller itself.
interface char_motion_ctrl_if;
   import char_motion_ctrl_pkg::*;

   logic           move_tick;
   logic           btn_up;
   logic           btn_down;
   logic           btn_fire;
   logic [3:0]     Event;
   logic [9:0]     d_x, d_y, d1_x, d1_y, d2_x, d2_y;
   logic [9:0]     r_x, r_y, m_x, m_y;
   logic           d_valid, d1_valid, d2_valid, r_valid, m_valid;
   logic [7:0]     score;
   logic           game_over;
   slot_state_e    d_state, d1_state, d2_state;
   missile_state_e m_state;

   modport master (
      output move_tick, btn_up, btn_down, btn_fire, Event,
      input  d_x, d_y, d1_x, d1_y, d2_x, d2_y, r_x, r_y, m_x, m_y,
      input  d_valid, d1_valid, d2_valid, r_valid, m_valid, score, game_over,
      input  d_state, d1_state, d2_state, m_state
   );

   modport slave (
      input  move_tick, btn_up, btn_down, btn_fire, Event,
      output d_x, d_y, d1_x, d1_y, d2_x, d2_y, r_x, r_y, m_x, m_y,
      output d_valid, d1_valid, d2_valid, r_valid, m_valid, score, game_over,
      output d_state, d1_state, d2_state, m_state
   );

endinterface

// File: rtl/char_motion_ctrl_dragon_slot.sv
// One dragon: walks left each tick, re-enters at the spawn column on escape, and after a kill
// stays invisible for a fixed number of ticks before reappearing at a fresh random row.
module dragon_slot
   import char_motion_ctrl_pkg::*;
#(
   parameter int DRAGON_STEP   = 2,
   parameter int RESPAWN_TICKS = 60,
   parameter int SPAWN_X       = 600
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tick,
   input  logic        kill,
   input  logic        freeze,
   input  logic [9:0]  init_y,
   input  logic [9:0]  spawn_y,
   output logic [9:0]  x,
   output logic [9:0]  y,
   output logic        valid,
   output logic        killed,
   output slot_state_e state
);

   localparam int         CW       = $clog2(RESPAWN_TICKS + 1);
   localparam logic [9:0] STEP     = 10'(DRAGON_STEP);
   localparam logic [9:0] X_SPAWN  = 10'(SPAWN_X);
   localparam logic [CW-1:0] CNT_INIT = CW'(RESPAWN_TICKS);

   slot_state_e   state_q, state_d;
   logic [9:0]    x_q, x_d, y_q, y_d;
   logic          valid_q, valid_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SLOT_ALIVE;
         x_q     <= X_SPAWN;
         y_q     <= init_y;
         valid_q <= 1'b1;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      killed  = 1'b0;
      if (!freeze) begin
         case (state_q)
            SLOT_ALIVE: begin
               if (kill) begin
                  valid_d = 1'b0;
                  cnt_d   = CNT_INIT;
                  state_d = SLOT_DEAD;
                  killed  = 1'b1;
               end else if (tick) begin
                  x_d = (x_q < STEP) ? X_SPAWN : x_q - STEP;
               end
            end
            SLOT_DEAD: begin
               // The tick that brings the count to zero is the one that respawns,
               // so the dragon is gone for exactly RESPAWN_TICKS ticks.
               if (tick) begin
                  if (cnt_q <= CW'(1)) begin
                     cnt_d   = '0;
                     x_d     = X_SPAWN;
                     y_d     = spawn_y;
                     valid_d = 1'b1;
                     state_d = SLOT_ALIVE;
                  end else begin
                     cnt_d = cnt_q - CW'(1);
                  end
               end
            end
            default: state_d = SLOT_ALIVE;
         endcase
      end
   end

   assign x     = x_q;
   assign y     = y_q;
   assign valid = valid_q;
   assign state = state_q;

endmodule

// File: rtl/char_motion_ctrl.sv
// Game-state stage ahead of the pixel generator: dragons, robot, missile, score and game-over,
// all advanced by move_tick and killed by rising bits of the pixel stage's Event broadcast.
module char_motion_ctrl
   import char_motion_ctrl_pkg::*;
#(
   parameter int DRAGON_STEP   = 2,
   parameter int MISSILE_STEP  = 6,
   parameter int ROBOT_STEP    = 3,
   parameter int RESPAWN_TICKS = 60,
   parameter int SPAWN_X       = 600
) (
   input  logic              clk_25Hz,
   input  logic              rst,
   char_motion_ctrl_if.slave bus
);

   localparam logic [9:0] R_STEP = 10'(ROBOT_STEP);
   localparam logic [9:0] M_STEP = 10'(MISSILE_STEP);

   logic [3:0]     ev_q, rise;
   logic [7:0]     lfsr_q;
   logic [9:0]     spawn_y;
   logic           tick;
   logic [2:0]     killed;
   logic [1:0]     n_killed;
   logic [8:0]     score_sum;

   logic [7:0]     score_q, score_d;
   logic           game_over_q, game_over_d;
   logic [9:0]     r_y_q, r_y_d;
   logic           r_valid_q, r_valid_d;
   missile_state_e m_state_q, m_state_d;
   logic [9:0]     m_x_q, m_x_d, m_y_q, m_y_d, m_x_next;
   logic           m_valid_q, m_valid_d;

   assign rise    = bus.Event & ~ev_q;
   assign tick    = bus.move_tick;
   assign spawn_y = SPAWN_Y_BASE + {2'b00, lfsr_q} + {3'b000, lfsr_q[7:1]};

   always_ff @(posedge clk_25Hz or negedge rst) begin
      if (!rst) begin
         ev_q        <= '0;
         lfsr_q      <= LFSR_SEED;
         score_q     <= '0;
         game_over_q <= 1'b0;
         r_y_q       <= ROBOT_Y0;
         r_valid_q   <= 1'b1;
         m_state_q   <= M_IDLE;
         m_x_q       <= '0;
         m_y_q       <= '0;
         m_valid_q   <= 1'b0;
      end else begin
         ev_q        <= bus.Event;
         lfsr_q      <= lfsr_next(lfsr_q);
         score_q     <= score_d;
         game_over_q <= game_over_d;
         r_y_q       <= r_y_d;
         r_valid_q   <= r_valid_d;
         m_state_q   <= m_state_d;
         m_x_q       <= m_x_d;
         m_y_q       <= m_y_d;
         m_valid_q   <= m_valid_d;
      end
   end

   dragon_slot #(.DRAGON_STEP(DRAGON_STEP), .RESPAWN_TICKS(RESPAWN_TICKS), .SPAWN_X(SPAWN_X)) u_d (
      .clk(clk_25Hz), .rst_n(rst), .tick(tick), .kill(rise[EV_D]), .freeze(game_over_q),
      .init_y(D_Y0), .spawn_y(spawn_y), .x(bus.d_x), .y(bus.d_y), .valid(bus.d_valid),
      .killed(killed[0]), .state(bus.d_state)
   );

   dragon_slot #(.DRAGON_STEP(DRAGON_STEP), .RESPAWN_TICKS(RESPAWN_TICKS), .SPAWN_X(SPAWN_X)) u_d1 (
      .clk(clk_25Hz), .rst_n(rst), .tick(tick), .kill(rise[EV_D1]), .freeze(game_over_q),
      .init_y(D1_Y0), .spawn_y(spawn_y), .x(bus.d1_x), .y(bus.d1_y), .valid(bus.d1_valid),
      .killed(killed[1]), .state(bus.d1_state)
   );

   dragon_slot #(.DRAGON_STEP(DRAGON_STEP), .RESPAWN_TICKS(RESPAWN_TICKS), .SPAWN_X(SPAWN_X)) u_d2 (
      .clk(clk_25Hz), .rst_n(rst), .tick(tick), .kill(rise[EV_D2]), .freeze(game_over_q),
      .init_y(D2_Y0), .spawn_y(spawn_y), .x(bus.d2_x), .y(bus.d2_y), .valid(bus.d2_valid),
      .killed(killed[2]), .state(bus.d2_state)
   );

   // A dragon that dies together with the robot was rammed, not shot: no score.
   assign n_killed  = {1'b0, killed[0]} + {1'b0, killed[1]} + {1'b0, killed[2]};
   assign score_sum = {1'b0, score_q} + {7'd0, n_killed};

   always_comb begin
      score_d     = score_q;
      game_over_d = game_over_q;
      r_y_d       = r_y_q;
      r_valid_d   = r_valid_q;
      if (!game_over_q) begin
         if (!rise[EV_R]) begin
            score_d = score_sum[8] ? 8'hFF : score_sum[7:0];
         end
         if (rise[EV_R]) begin
            r_valid_d   = 1'b0;
            game_over_d = 1'b1;
         end else if (tick && bus.btn_up && !bus.btn_down) begin
            r_y_d = (r_y_q < R_STEP) ? 10'd0 : r_y_q - R_STEP;
         end else if (tick && bus.btn_down && !bus.btn_up) begin
            r_y_d = (r_y_q + R_STEP > ROBOT_Y_MAX) ? ROBOT_Y_MAX : r_y_q + R_STEP;
         end
      end
   end

   assign m_x_next = m_x_q + M_STEP;

   always_comb begin
      m_state_d = m_state_q;
      m_x_d     = m_x_q;
      m_y_d     = m_y_q;
      m_valid_d = m_valid_q;
      if (!game_over_q) begin
         case (m_state_q)
            M_IDLE: begin
               if (tick && bus.btn_fire && r_valid_q && !rise[EV_R]) begin
                  m_x_d     = ROBOT_X + MISSILE_X_OFF;
                  m_y_d     = r_y_q + MISSILE_Y_OFF;
                  m_valid_d = 1'b1;
                  m_state_d = M_FLY;
               end
            end
            M_FLY: begin
               if (|rise[EV_D:EV_D2]) begin
                  m_valid_d = 1'b0;
                  m_state_d = M_IDLE;
               end else if (tick) begin
                  m_x_d = m_x_next;
                  if (m_x_next > MISSILE_X_MAX) begin
                     m_valid_d = 1'b0;
                     m_state_d = M_IDLE;
                  end
               end
            end
            default: m_state_d = M_IDLE;
         endcase
      end
   end

   assign bus.r_x       = ROBOT_X;
   assign bus.r_y       = r_y_q;
   assign bus.r_valid   = r_valid_q;
   assign bus.m_x       = m_x_q;
   assign bus.m_y       = m_y_q;
   assign bus.m_valid   = m_valid_q;
   assign bus.m_state   = m_state_q;
   assign bus.score     = score_q;
   assign bus.game_over = game_over_q;

endmodule

// File: doc/char_motion_ctrl.md
# char_motion_ctrl

Game-state stage directly upstream of the sprite/pixel generator: owns the positions and valid flags of three dragons, the robot and the missile, and feeds them to the pixel stage every VGA frame. It consumes the pixel stage's collision broadcast `Event` to kill characters, respawn dragons, retire the missile, count score and latch game-over. All state advances on a one-cycle `move_tick` strobe, so the VGA pixel clock stays the only clock.

## Interface
Parameters:
- `DRAGON_STEP`, 2: dragon leftward pixels per tick.
- `MISSILE_STEP`, 6: missile rightward pixels per tick.
- `ROBOT_STEP`, 3: robot vertical pixels per tick.
- `RESPAWN_TICKS`, 60: ticks a dead dragon stays invisible.
- `SPAWN_X`, 600: dragon spawn/re-entry column.

Ports (one clock; reset is asynchronous and active-low):
- `clk_25Hz`  in  1  25 MHz pixel clock, sole clock.
- `rst`  in  1  async active-low reset.
- `move_tick`  in  1  one-cycle motion strobe, nominally once per frame.
- `btn_up`, `btn_down`, `btn_fire`  in  1 each  debounced level inputs.
- `Event`  in  4  collision broadcast `{d, d1, d2, r}`, held many cycles per event.
- `d_x`, `d_y`, `d1_x`, `d1_y`, `d2_x`, `d2_y`  out  10 each  dragon top-left.
- `r_x`, `r_y`  out  10 each  robot top-left.
- `m_x`, `m_y`  out  10 each  missile top-left.
- `d_valid`, `d1_valid`, `d2_valid`, `r_valid`, `m_valid`  out  1 each  visible/alive.
- `score`  out  8  dragons killed by missile, saturating.
- `game_over`  out  1  sticky after robot death.

## Operation
- Reset values: dragons x=`SPAWN_X`; y = 60 / 200 / 340; all dragon valids = 1.
- Robot: x=20, y=225, valid=1. Missile: x=0, y=0, valid=0. `score`=0, `game_over`=0.
- LFSR: 8 bits, x^8+x^6+x^5+x^4+1, seed 8'hA5, reset 8'hA5, advances every clock.
- Event edges: `ev_q` (reset 0) samples `Event` each cycle. `rise = Event & ~ev_q`. Only `rise` bits act, so a held Event acts once; a changed nonzero Event acts on newly set bits only.
- Dragon slot FSM:
  - ALIVE: on tick, x -= `DRAGON_STEP`. If x < `DRAGON_STEP` before the move, x = `SPAWN_X` instead (escape, no score).
  - ALIVE, own rise bit: valid=0, cnt=`RESPAWN_TICKS`, go to DEAD. `score` += 1 only if `rise[0]`=0 in the same cycle.
  - DEAD: on tick, cnt -= 1. When cnt is 0 at a tick: x=`SPAWN_X`, y = 40 + lfsr + lfsr[7:1] (range 40..422), valid=1, go to ALIVE.
  - DEAD ignores further rise bits.
- Robot:
  - On tick with btn_up: y = max(y−`ROBOT_STEP`, 0).
  - On tick with btn_down: y = min(y+`ROBOT_STEP`, 450).
  - Both buttons pressed: no move.
  - `rise[0]`: r_valid=0, game_over=1.
- Missile FSM:
  - IDLE: on tick with btn_fire and r_valid: m_x = r_x+40, m_y = r_y+9, valid=1, go to FLY.
  - FLY: on tick, m_x += `MISSILE_STEP`. If the new m_x > 583 (sprite 56 wide would pass 640), go to IDLE, valid=0.
  - Any of `rise[3:1]` while in FLY: go to IDLE, valid=0.
- game_over freezes everything except `ev_q`/LFSR: no motion, no fire, no respawn, score frozen. Positions and valids hold. Only reset clears it.
- Priority in one cycle:
  - reset > game_over freeze > rise > tick.
  - A rise and a tick in the same cycle: the rise is applied and that slot's tick is skipped.
  - Robot death and dragon death in the same cycle: both die, no score.

## Timing
- All outputs are registered; no combinational input-to-output path.
- Position update is visible the cycle after the `move_tick` cycle.
- Kill is visible (valid=0) the cycle after `Event` rises, i.e. two cycles after the pixel stage raises its internal die.
- Score saturates at 255. Subtraction guards ensure x never wraps below 0.
- Reset may arrive mid-flight or mid-respawn: all state returns asynchronously to the reset values.

## Structure
- Shared constants file `game_defs.vh`:
  - screen 640×480;
  - dragon 40×30, robot 40×30, missile 56×12;
  - reset y values;
  - robot x=20, robot y max 450;
  - `Event` bit indices.
- One sub-module, `dragon_slot`, instantiated three times. Ports: clock, reset, tick, kill, freeze, init_y, spawn_y; outputs x, y, valid, killed pulse.
- Missile, robot, LFSR and score logic stay in the top.

## Test plan
- Reset, then 10 ticks, no input → d_x = 580, robot at (20, 225), m_valid = 0.
- btn_fire on one tick → m = (60, 234), valid = 1. Then 90 more ticks → m_valid = 0 once m_x exceeds 583.
- Missile in flight; Event = 4'b1000 held 1000 cycles → d_valid = 0 and m_valid = 0 once, score = 1. After 60 ticks d_valid = 1, d_x = 600, d_y in 40..422.
- Event = 4'b0101 → d1_valid = 0, r_valid = 0, game_over = 1, score unchanged. Further ticks → no position changes.
- btn_up held 100 ticks from y = 225 → r_y = 0 (clamped). btn_down held 200 ticks → r_y = 450.
- Dragon at x = 1 with tick → x = 600. Same cycle as Event rise → die only, x unchanged.
